// File: rtl/coin_pulse_classifier.sv
// Coin pulse classifier: measures each sync'd sensor pulse and emits a one-cycle dime/nickel/quarter pulse.
// Optional COIN_REJECT_EN adds coinRejected for out-of-band pulses; detect latency is 3 clk from the raw falling edge.
module coin_pulse_classifier #(
   parameter int dimeMin    = 380000,
   parameter int dimeMax    = 420000,
   parameter int nickelMin  = 480000,
   parameter int nickelMax  = 520000,
   parameter int quarterMin = 580000,
   parameter int quarterMax = 620000,
   parameter int countWidth = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic coinSensor,
   output logic dimeDetected,
   output logic nickelDetected,
`ifdef COIN_REJECT_EN
   output logic quarterDetected,
   output logic coinRejected
`else
   output logic quarterDetected
`endif
);

   typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

   localparam logic [countWidth-1:0] CNT_ONE = {{(countWidth-1){1'b0}}, 1'b1};
   localparam logic [countWidth-1:0] CNT_MAX = {countWidth{1'b1}};

   state_t                state_q, state_d;
   logic [countWidth-1:0] count_q, count_d;
   logic                  sync1_q, sync_q;
   logic                  dime_q, dime_d;
   logic                  nickel_q, nickel_d;
   logic                  quarter_q, quarter_d;
   logic                  reject_q, reject_d;
   logic [31:0]           count_ext;
   logic                  in_dime, in_nickel, in_quarter;

   // Compare in 32 bits so the int-typed thresholds never truncate.
   assign count_ext  = 32'(count_q);
   assign in_dime    = (count_ext >= 32'(dimeMin))    && (count_ext <= 32'(dimeMax));
   assign in_nickel  = (count_ext >= 32'(nickelMin))  && (count_ext <= 32'(nickelMax));
   assign in_quarter = (count_ext >= 32'(quarterMin)) && (count_ext <= 32'(quarterMax));

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      dime_d    = 1'b0;
      nickel_d  = 1'b0;
      quarter_d = 1'b0;
      reject_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync_q) begin
               state_d = MEASURE;
               count_d = CNT_ONE;
            end
         end
         MEASURE: begin
            if (sync_q) begin
               count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
            end else begin
               // Detect flops load here so they are high during the REPORT cycle.
               state_d   = REPORT;
               dime_d    = in_dime;
               nickel_d  = !in_dime && in_nickel;
               quarter_d = !in_dime && !in_nickel && in_quarter;
               reject_d  = !in_dime && !in_nickel && !in_quarter;
            end
         end
         REPORT: begin
            if (sync_q) begin
               state_d = MEASURE;
               count_d = CNT_ONE;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b0;
         sync_q    <= 1'b0;
         state_q   <= IDLE;
         count_q   <= '0;
         dime_q    <= 1'b0;
         nickel_q  <= 1'b0;
         quarter_q <= 1'b0;
         reject_q  <= 1'b0;
      end else begin
         sync1_q   <= coinSensor;
         sync_q    <= sync1_q;
         state_q   <= state_d;
         count_q   <= count_d;
         dime_q    <= dime_d;
         nickel_q  <= nickel_d;
         quarter_q <= quarter_d;
         reject_q  <= reject_d;
      end
   end

   assign dimeDetected    = dime_q;
   assign nickelDetected  = nickel_q;
   assign quarterDetected = quarter_q;
`ifdef COIN_REJECT_EN
   assign coinRejected    = reject_q;
`else
   logic unused_reject;
   assign unused_reject   = reject_q;
`endif

endmodule

// File: tb/tb_coin_pulse_classifier.sv
// Directed bench for coin_pulse_classifier with small thresholds (countWidth=8).
module tb_coin_pulse_classifier;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic coinSensor = 1'b0;
   logic dimeDetected, nickelDetected, quarterDetected;
   logic rej;
   logic [3:0] outs;
   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   coin_pulse_classifier #(
      .dimeMin(38), .dimeMax(42), .nickelMin(48), .nickelMax(52),
      .quarterMin(58), .quarterMax(62), .countWidth(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .coinSensor(coinSensor),
      .dimeDetected(dimeDetected),
      .nickelDetected(nickelDetected),
`ifdef COIN_REJECT_EN
      .quarterDetected(quarterDetected),
      .coinRejected(rej)
`else
      .quarterDetected(quarterDetected)
`endif
   );

`ifndef COIN_REJECT_EN
   assign rej = 1'b0;
`endif

   // outs = {reject, quarter, nickel, dime}
   assign outs = {rej, quarterDetected, nickelDetected, dimeDetected};

   localparam logic [2:0] C_NONE = 3'b000;
   localparam logic [2:0] C_DIME = 3'b001;
   localparam logic [2:0] C_NICK = 3'b010;
   localparam logic [2:0] C_QUAR = 3'b100;

   function automatic logic [3:0] expv(input logic [2:0] cls);
`ifdef COIN_REJECT_EN
      return {(cls == 3'b000), cls};
`else
      return {1'b0, cls};
`endif
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sensor high n cycles then low; pulse due on the 3rd edge after the fall.
   task automatic coin(input int n, input logic [2:0] cls, input string tag);
      coinSensor = 1'b1;
      repeat (n) tick();
      check({tag, " during"}, outs, 4'b0000);
      coinSensor = 1'b0;
      tick();
      check({tag, " lat1"}, outs, 4'b0000);
      tick();
      check({tag, " lat2"}, outs, 4'b0000);
      tick();
      check({tag, " hit"}, outs, expv(cls));
      tick();
      check({tag, " after"}, outs, 4'b0000);
      repeat (3) tick();
   endtask

   initial begin
      #1;
      check("reset_state", outs, 4'b0000);
      repeat (2) tick();
      reset = 1'b1;
      repeat (3) tick();
      check("idle_after_reset", outs, 4'b0000);

      coin(40, C_DIME, "dime40");
      coin(48, C_NICK, "nickel48_min");
      coin(62, C_QUAR, "quarter62_max");
      coin(52, C_NICK, "nickel52_max");
      coin(38, C_DIME, "dime38_min");
      coin(42, C_DIME, "dime42_max");
      coin(37, C_NONE, "below_dime37");
      coin(58, C_QUAR, "quarter58_min");
      coin(45, C_NONE, "gap45");
      coin(300, C_NONE, "saturate300");

      // Back-to-back: 50 high, 1 low, 40 high.
      coinSensor = 1'b1;
      repeat (50) tick();
      coinSensor = 1'b0;
      tick();
      coinSensor = 1'b1;
      tick();
      check("b2b lat2", outs, 4'b0000);
      tick();
      check("b2b nickel", outs, expv(C_NICK));
      tick();
      check("b2b after", outs, 4'b0000);
      repeat (37) tick();
      coinSensor = 1'b0;
      tick();
      check("b2b2 lat1", outs, 4'b0000);
      tick();
      check("b2b2 lat2", outs, 4'b0000);
      tick();
      check("b2b2 dime", outs, expv(C_DIME));
      tick();
      check("b2b2 after", outs, 4'b0000);
      repeat (3) tick();

      // Reset mid-measure, remnant of the 60-cycle pulse stays high.
      coinSensor = 1'b1;
      repeat (30) tick();
      reset = 1'b0;
      #1;
      check("reset_mid_outs", outs, 4'b0000);
      repeat (2) tick();
      check("reset_held_outs", outs, 4'b0000);
      reset = 1'b1;
      coin(28, C_NONE, "remnant28");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/coin_pulse_classifier.md
COIN_PULSE_CLASSIFIER -- requirements
Module: coin_pulse_classifier

Interface
REQ-001 SHALL have parameter dimeMin, default 380000: minimum dime pulse width in clk cycles, inclusive.
REQ-002 SHALL have parameter dimeMax, default 420000: maximum dime pulse width in clk cycles, inclusive.
REQ-003 SHALL have parameter nickelMin, default 480000: minimum nickel pulse width in clk cycles, inclusive.
REQ-004 SHALL have parameter nickelMax, default 520000: maximum nickel pulse width in clk cycles, inclusive.
REQ-005 SHALL have parameter quarterMin, default 580000: minimum quarter pulse width in clk cycles, inclusive.
REQ-006 SHALL have parameter quarterMax, default 620000: maximum quarter pulse width in clk cycles, inclusive.
REQ-007 SHALL have parameter countWidth, default 20: width of the pulse-width counter.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port coinSensor, input, 1 bit: raw asynchronous sensor, high while a coin occludes it.
REQ-011 SHALL have port dimeDetected, output, 1 bit: one-cycle pulse, dime classified.
REQ-012 SHALL have port nickelDetected, output, 1 bit: one-cycle pulse, nickel classified.
REQ-013 SHALL have port quarterDetected, output, 1 bit: one-cycle pulse, quarter classified.
REQ-014 SHALL have port coinRejected, output, 1 bit: one-cycle pulse, out-of-band pulse; present only with COIN_REJECT_EN.

Function
REQ-015 SHALL pass coinSensor through a two-flop synchronizer; only the second-stage signal (sync) is used downstream.
REQ-016 SHALL implement states IDLE, MEASURE, REPORT.
REQ-017 IDLE: sync=1 -> MEASURE, count loaded with 1; otherwise stay, count held.
REQ-018 MEASURE: sync=1 -> count increments by 1, saturating at 2^countWidth-1 (no wrap); sync=0 -> REPORT, count held.
REQ-019 REPORT: lasts exactly one cycle; the registered detect outputs carry the classification of count during this cycle.
REQ-020 REPORT exit: sync=1 -> MEASURE with count loaded with 1 (back-to-back coins lose no cycles); otherwise -> IDLE.
REQ-021 Classification SHALL use inclusive ranges with priority dime > nickel > quarter; at most one of dime/nickel/quarter pulses per coin.
REQ-022 A count outside all ranges, including a saturated count, SHALL produce no dime/nickel/quarter pulse.
REQ-023 Latency SHALL be: raw coinSensor falling edge to detect pulse = 3 clk cycles (2 synchronizer + 1 REPORT register).
REQ-024 A sync high pulse of N cycles SHALL yield count = N (saturated) at REPORT.
REQ-025 Outputs SHALL be driven from flops and be 0 in every cycle other than the REPORT output cycle.
REQ-026 Sensor activity SHALL never be ignored; there is no lockout after REPORT.

Reset
REQ-027 reset low SHALL asynchronously clear synchronizer flops, count to 0, state to IDLE, and all outputs to 0.
REQ-028 Reset asserted mid-MEASURE SHALL discard the partial measurement; no pulse is emitted for that coin.
REQ-029 After reset release, a sensor already high SHALL be measured from the first cycle sync=1.

Configuration
REQ-030 Macro COIN_REJECT_EN defined: coinRejected port exists and pulses in the REPORT output cycle whenever REQ-022 applies.
REQ-031 Macro COIN_REJECT_EN undefined: coinRejected port and its logic are absent; all other behaviour is identical.

Verification (bench parameters: dimeMin=38, dimeMax=42, nickelMin=48, nickelMax=52, quarterMin=58, quarterMax=62, countWidth=8)
REQ-032 Sensor high 40 cycles -> dimeDetected high exactly 1 cycle, 3 cycles after the falling edge; nickelDetected and quarterDetected stay 0.
REQ-033 Sensor high 48, then 62, then 52 cycles -> nickel pulse, quarter pulse, nickel pulse; boundaries are inclusive.
REQ-034 Sensor high 45 cycles, then 300 cycles -> no detect pulses; coinRejected pulses twice when COIN_REJECT_EN is defined; the 300-cycle count saturates at 255.
REQ-035 Sensor high 50 cycles, low 1 cycle, high 40 cycles -> nickel pulse followed by dime pulse, with no cycle lost on the second coin.
REQ-036 Reset low for 2 cycles after 30 cycles of a 60-cycle pulse -> outputs 0 immediately; the pulse remnant of about 28 cycles produces no pulse, plus coinRejected if COIN_REJECT_EN is defined.
